// File: rtl/cpu_ctrl_mc_pkg.sv
// Shared constants for the multi-cycle CPU controller: opcodes, FSM states,
// operand-B source and data-memory address-mode encodings.
package cpu_ctrl_mc_pkg;

    // Opcodes with MSB=1 are ALU-register ops; the low bits select the ALU operation.
    localparam logic [4:0] OP_RST  = 5'h00;
    localparam logic [4:0] OP_LDI  = 5'h01;
    localparam logic [4:0] OP_LDR  = 5'h02;
    localparam logic [4:0] OP_STR  = 5'h03;
    localparam logic [4:0] OP_BAR  = 5'h04;
    localparam logic [4:0] OP_JMP  = 5'h05;
    localparam logic [4:0] OP_JMPO = 5'h06;
    localparam logic [4:0] OP_LD   = 5'h07;
    localparam logic [4:0] OP_ST   = 5'h08;
    localparam logic [4:0] OP_LDAR = 5'h09;
    localparam logic [4:0] OP_PUSH = 5'h0A;
    localparam logic [4:0] OP_POP  = 5'h0B;

    localparam logic [1:0] ST_FETCH = 2'b00;
    localparam logic [1:0] ST_EXEC  = 2'b01;
    localparam logic [1:0] ST_MEM   = 2'b10;

    localparam logic [1:0] BSEL_IMM = 2'b00;
    localparam logic [1:0] BSEL_REG = 2'b01;
    localparam logic [1:0] BSEL_MEM = 2'b10;

    localparam logic [1:0] AM_OPND  = 2'b00;
    localparam logic [1:0] AM_REG   = 2'b01;
    localparam logic [1:0] AM_STACK = 2'b10;

endpackage

// File: rtl/cpu_ctrl_mc_stack_ptr.sv
// Stack pointer (0..DEPTH) with sticky over/underflow flag and the slot index
// presented for the pending PUSH (SP) or POP (SP-1).
module cpu_stack_ptr #(
    parameter int DEPTH = 8,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clr,
    input  logic           i_push,
    input  logic           i_pop,
    input  logic           i_err_set,
    input  logic           i_pop_sel,
    output logic [SPW-1:0] o_sp,
    output logic [SPW-1:0] o_addr,
    output logic           o_full,
    output logic           o_empty,
    output logic           o_err
);
    logic [SPW-1:0] r_sp;
    logic           r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_clr)
                r_sp <= '0;
            else if (i_push && !o_full)
                r_sp <= r_sp + 1'b1;
            else if (i_pop && !o_empty)
                r_sp <= r_sp - 1'b1;
            if (i_err_set)
                r_err <= 1'b1;
        end
    end

    assign o_sp    = r_sp;
    assign o_full  = (r_sp == SPW'(DEPTH));
    assign o_empty = (r_sp == '0);
    assign o_err   = r_err;
    // An empty-stack POP never reaches memory; report slot 0 rather than a wrapped index.
    assign o_addr  = i_pop_sel ? (o_empty ? '0 : r_sp - 1'b1) : r_sp;
endmodule

// File: rtl/cpu_ctrl_mc.sv
// Multi-cycle CPU controller: FETCH -> EXEC (-> MEM until D_MEM_RDY) -> FETCH,
// decoding a latched instruction register into datapath strobes and selects.
module cpu_ctrl_mc
    import cpu_ctrl_mc_pkg::*;
#(
    parameter int WIDTH          = 13,
    parameter int IWIDTH         = 5,
    parameter int REG_F_SEL_SIZE = 4,
    parameter int STACK_DEPTH    = 8,
    parameter int OW             = WIDTH - IWIDTH,
    parameter int SPW            = $clog2(STACK_DEPTH + 1)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [WIDTH-1:0]          IN,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic                      D_MEM_RDY,
    output logic                      PC_RST,
    output logic                      PC_INC,
    output logic                      PC_LD,
    output logic                      JMP_MODE,
    output logic [IWIDTH-2:0]         ALU_OUT,
    output logic [OW-1:0]             OPERAND,
    output logic [1:0]                IN_B_SEL,
    output logic [REG_F_SEL_SIZE-1:0] REG_F_SEL,
    output logic                      EN_REG_F,
    output logic                      EN_D_MEM,
    output logic                      EN_ACC,
    output logic                      BASE_REG_LD,
    output logic [1:0]                D_MEM_ADDR_MODE,
    output logic [SPW-1:0]            STACK_ADDR,
    output logic                      STACK_ERR
);
    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_ir;
    logic [IWIDTH-1:0] w_op;
    logic              w_alu, w_ld, w_st, w_ldar, w_push, w_pop, w_mem_op;
    logic              w_full, w_empty, w_stk_err, w_done;
    logic [SPW-1:0]    w_sp;

    assign w_op      = r_ir[WIDTH-1:OW];
    assign w_alu     = r_ir[WIDTH-1];
    assign w_ld      = (w_op == IWIDTH'(OP_LD));
    assign w_st      = (w_op == IWIDTH'(OP_ST));
    assign w_ldar    = (w_op == IWIDTH'(OP_LDAR));
    assign w_push    = (w_op == IWIDTH'(OP_PUSH));
    assign w_pop     = (w_op == IWIDTH'(OP_POP));
    assign w_mem_op  = w_ld | w_st | w_ldar | w_push | w_pop;
    assign w_stk_err = (w_push && w_full) || (w_pop && w_empty);
    assign w_done    = (r_state == ST_MEM) && D_MEM_RDY && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_FETCH;
            r_ir    <= '0;
        end else begin
            case (r_state)
                ST_FETCH: if (IN_VALID) begin
                    r_ir    <= IN;
                    r_state <= ST_EXEC;
                end
                ST_EXEC:  r_state <= (w_mem_op && !w_stk_err) ? ST_MEM : ST_FETCH;
                ST_MEM:   if (D_MEM_RDY) r_state <= ST_FETCH;
                default:  r_state <= ST_FETCH;
            endcase
        end
    end

    // Selects depend only on IR so they stay stable from EXEC through MEM.
    assign IN_READY  = (r_state == ST_FETCH);
    assign OPERAND   = r_ir[OW-1:0];
    assign ALU_OUT   = r_ir[WIDTH-2:OW];
    assign REG_F_SEL = r_ir[REG_F_SEL_SIZE-1:0];
    assign JMP_MODE  = !w_alu && (w_op == IWIDTH'(OP_JMPO));

    always_comb begin
        IN_B_SEL        = BSEL_MEM;
        D_MEM_ADDR_MODE = AM_OPND;
        if (w_alu || w_op == IWIDTH'(OP_LDR))
            IN_B_SEL = BSEL_REG;
        else if (w_op == IWIDTH'(OP_LDI))
            IN_B_SEL = BSEL_IMM;
        if (w_ldar)
            D_MEM_ADDR_MODE = AM_REG;
        else if (w_push || w_pop)
            D_MEM_ADDR_MODE = AM_STACK;
    end

    always_comb begin
        PC_RST      = 1'b0;
        PC_INC      = 1'b0;
        PC_LD       = 1'b0;
        EN_REG_F    = 1'b0;
        EN_D_MEM    = 1'b0;
        EN_ACC      = 1'b0;
        BASE_REG_LD = 1'b0;
        if (!RST && r_state == ST_EXEC) begin
            if (w_alu) begin
                EN_ACC = 1'b1;
                PC_INC = 1'b1;
            end else begin
                case (w_op)
                    IWIDTH'(OP_RST):  PC_RST = 1'b1;
                    IWIDTH'(OP_LDI),
                    IWIDTH'(OP_LDR):  begin EN_ACC = 1'b1; PC_INC = 1'b1; end
                    IWIDTH'(OP_STR):  begin EN_REG_F = 1'b1; PC_INC = 1'b1; end
                    IWIDTH'(OP_BAR):  begin BASE_REG_LD = 1'b1; PC_INC = 1'b1; end
                    IWIDTH'(OP_JMP),
                    IWIDTH'(OP_JMPO): PC_LD = 1'b1;
                    IWIDTH'(OP_LD), IWIDTH'(OP_ST), IWIDTH'(OP_LDAR),
                    IWIDTH'(OP_PUSH), IWIDTH'(OP_POP): PC_INC = w_stk_err;
                    default:          PC_INC = 1'b1;
                endcase
            end
        end else if (w_done) begin
            PC_INC   = 1'b1;
            EN_ACC   = w_ld | w_ldar | w_pop;
            EN_D_MEM = w_st | w_push;
        end
    end

    cpu_stack_ptr #(.DEPTH(STACK_DEPTH), .SPW(SPW)) u_sp (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_clr     (r_state == ST_EXEC && !w_alu && w_op == IWIDTH'(OP_RST)),
        .i_push    (w_done && w_push),
        .i_pop     (w_done && w_pop),
        .i_err_set (r_state == ST_EXEC && w_stk_err),
        .i_pop_sel (w_pop),
        .o_sp      (w_sp),
        .o_addr    (STACK_ADDR),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_err     (STACK_ERR)
    );
endmodule

// File: doc/cpu_ctrl_mc.md
CPU_CTRL_MC -- requirements
Module: cpu_ctrl_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 13, meaning instruction width.
REQ-002 SHALL have parameter IWIDTH, default 5, meaning opcode width; operand width OW = WIDTH-IWIDTH.
REQ-003 SHALL have parameter REG_F_SEL_SIZE, default 4, meaning register-file select width.
REQ-004 SHALL have parameter STACK_DEPTH, default 8, meaning stack entries; SPW = clog2(STACK_DEPTH+1).
REQ-005 SHALL have port CLK  in  1  meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST  in  1  meaning reset, synchronous and active-high.
REQ-007 SHALL have port IN  in  WIDTH  meaning instruction word from instruction memory.
REQ-008 SHALL have port IN_VALID  in  1  meaning IN holds a valid instruction.
REQ-009 SHALL have port IN_READY  out  1  meaning controller accepts an instruction this cycle.
REQ-010 SHALL have port D_MEM_RDY  in  1  meaning data memory completes the access this cycle.
REQ-011 SHALL have port PC_RST / PC_INC / PC_LD  out  1 each  meaning PC reset, increment, load.
REQ-012 SHALL have port JMP_MODE  out  1  meaning 0 absolute jump, 1 base-relative jump.
REQ-013 SHALL have port ALU_OUT  out  IWIDTH-1  meaning ALU operation = IR[WIDTH-2:OW].
REQ-014 SHALL have port OPERAND  out  OW  meaning latched operand field (immediate, address, base data, jump offset).
REQ-015 SHALL have port IN_B_SEL  out  2  meaning 00 immediate, 01 register file, 10 data memory.
REQ-016 SHALL have port REG_F_SEL  out  REG_F_SEL_SIZE  meaning register select = IR[REG_F_SEL_SIZE-1:0].
REQ-017 SHALL have port EN_REG_F / EN_D_MEM / EN_ACC / BASE_REG_LD  out  1 each  meaning write strobes.
REQ-018 SHALL have port D_MEM_ADDR_MODE  out  2  meaning 00 OPERAND, 01 register R0-R7, 10 STACK_ADDR.
REQ-019 SHALL have port STACK_ADDR  out  SPW  meaning stack slot index for the current stack access.
REQ-020 SHALL have port STACK_ERR  out  1  meaning sticky overflow/underflow flag.

Function
REQ-021 SHALL implement FSM states FETCH, EXEC, MEM; IN_READY=1 only in FETCH.
REQ-022 SHALL in FETCH latch IN into IR on IN_VALID=1 and go to EXEC; otherwise remain in FETCH with all strobes 0.
REQ-023 SHALL in EXEC, for RST/STR/BAR/JMP/JMPO/LDR/LDI/ALU-register ops/unknown opcodes, assert the single-cycle strobes of the original decode table, then return to FETCH (2 cycles per instruction).
REQ-024 SHALL in EXEC, for LD/ST/LDAR/PUSH/POP, go to MEM with no strobes; MEM holds address mode, OPERAND, STACK_ADDR, IN_B_SEL stable until D_MEM_RDY=1.
REQ-025 SHALL in the MEM cycle with D_MEM_RDY=1 pulse EN_ACC (LD/LDAR/POP) or EN_D_MEM (ST/PUSH) and return to FETCH.
REQ-026 SHALL pulse PC_INC in the last cycle of every instruction except JMP/JMPO (PC_LD) and RST opcode (PC_RST); never two PC strobes at once.
REQ-027 SHALL keep SP counter 0..STACK_DEPTH; PUSH uses STACK_ADDR=SP then SP+1; POP uses STACK_ADDR=SP-1 then SP-1; SP updates in the completing MEM cycle.
REQ-028 SHALL treat PUSH with SP=STACK_DEPTH or POP with SP=0 as error: set STACK_ERR, no memory strobe, SP unchanged, completes in EXEC with PC_INC.
REQ-029 SHALL clear SP to 0 on the RST opcode; STACK_ERR unaffected.
REQ-030 SHALL treat unknown opcodes as NOP with PC_INC.

Reset
REQ-031 SHALL on RST=1 at a clock edge enter FETCH, clear IR, SP, STACK_ERR; all strobes 0, IN_B_SEL=10, D_MEM_ADDR_MODE=00; RST overrides IN_VALID and D_MEM_RDY.
REQ-032 SHALL abandon an in-flight MEM access on reset with no strobe issued.

Structure
REQ-033 SHALL take opcodes, including new PUSH and POP, from shared instr_set.v; FSM state and IN_B_SEL/ADDR_MODE encodings belong in the same shared constants file.
REQ-034 SHALL place SP counter and error logic in sub-module cpu_stack_ptr.

Verification
REQ-035 LDI 0x5A, IN_VALID=1 -> next cycle OPERAND=0x5A, IN_B_SEL=00, EN_ACC=1, PC_INC=1 for exactly one cycle.
REQ-036 LD 0x10 with D_MEM_RDY low 3 cycles -> ADDR_MODE=00, OPERAND=0x10 held; EN_ACC+PC_INC pulse only in the D_MEM_RDY=1 cycle.
REQ-037 Eight PUSHes then ninth PUSH -> STACK_ADDR 0..7, SP=8; ninth sets STACK_ERR, no EN_D_MEM, PC_INC asserted.
REQ-038 POP at SP=0 -> STACK_ERR=1, no EN_ACC; after PUSH, POP uses STACK_ADDR=0, SP returns 0.
REQ-039 RST asserted during MEM of ST -> next cycle FETCH, no EN_D_MEM, SP=0, STACK_ERR=0.
REQ-040 JMPO 0x03 -> PC_LD=1, JMP_MODE=1, OPERAND=0x03, PC_INC=0.
